iob_cycle_ctl: RTL and testbench
================================

Name: iob_cycle_ctl

Overview:
- Consumes the IOB-domain select (IOCS, IACS) from the chip-select decoder and runs each selected CPU access as a request/acknowledge cycle on the slow I/O bus.
- Covers SCSI, SCC, IWM, VIA, IACK and video-RAM write cycles.
- Terminates the CPU cycle with nDTACK when the I/O side acknowledges, or with nBERR on timeout.
- Sits between the decoder and the I/O bus interface logic, clocked by the CPU-side clock.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the asynchronous IOACK input (legal 2..3).
- TIMEOUT, 255: CLK cycles in REQ without an acknowledge before bus error (legal 1..1023).

Ports:
- CLK  in  1  CPU-side clock; all state updates on rising edge.
- RES  in  1  asynchronous, active-high reset.
- nAS  in  1  CPU address strobe, active low, synchronous to CLK.
- nWE  in  1  CPU write strobe, active low; sampled at cycle start.
- IOCS  in  1  decoder: access targets the IOB domain.
- IACS  in  1  decoder: interrupt-acknowledge space.
- IOACK  in  1  I/O bus acknowledge, asynchronous to CLK, level (four-phase).
- IOREQ  out  1  I/O bus request, level.
- IOWE  out  1  I/O cycle is a write; valid whenever IOREQ=1.
- IOIACK  out  1  I/O cycle is an interrupt acknowledge; valid whenever IOREQ=1.
- nDTACK  out  1  CPU cycle termination, active low.
- nBERR  out  1  CPU bus error, active low.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; IOREQ=0, IOWE=0, IOIACK=0, nDTACK=1, nBERR=1, Busy=0; timeout counter 0; synchronizer chain 0. All outputs are registered.
- IOACK passes through SYNC_STAGES flops to give ack_s. No other input is synchronized.
- States: IDLE, REQ, TERM, ERR, RELEASE.
- IDLE:
  - On an edge sampling nAS=0 and IOCS=1: latch IOWE=~nWE and IOIACK=IACS, set IOREQ=1, clear the counter, go to REQ.
  - IOREQ is therefore high 1 edge after the strobe is sampled.
  - IACS without IOCS is ignored; the decoder always asserts both.
- REQ:
  - Counter increments each edge, saturating at TIMEOUT.
  - ack_s=1: IOREQ=0, nDTACK=0, go to TERM.
  - Otherwise, counter==TIMEOUT: IOREQ=0, nBERR=0, go to ERR.
  - If ack_s and timeout coincide, ack wins.
  - nAS=1 (aborted cycle): IOREQ=0, go to RELEASE; no termination is driven.
- Ack latency: if IOACK is first sampled high at edge K, nDTACK goes low at edge K+SYNC_STAGES.
- TERM: hold nDTACK=0 until nAS sampled 1; then nDTACK=1, go to RELEASE.
- ERR: hold nBERR=0 until nAS sampled 1; then nBERR=1, go to RELEASE.
- RELEASE:
  - Wait until ack_s=0 and nAS=1, then go to IDLE and clear IOWE and IOIACK.
  - This prevents a stale acknowledge from satisfying the next request.
  - An ack that arrives after a timeout or abort is absorbed here.
- Back-to-back: a new cycle with nAS already low while in RELEASE is not accepted. It is accepted in IDLE on the first edge where all conditions hold, so a new cycle starts no earlier than 1 edge after RELEASE exits.
- nDTACK and nBERR are never low simultaneously; at most one termination per CPU cycle.
- IOWE and IOIACK are stable for the whole interval IOREQ=1.
- RES mid-cycle: immediately drops IOREQ and restores all outputs to reset values. The I/O side sees IOREQ fall and must drop IOACK.
- Counter width: clog2(TIMEOUT+1) bits. The compare is exact equality; the counter never wraps.

Decomposition:
- Shared package iob_pkg:
  - state enum (IDLE, REQ, TERM, ERR, RELEASE);
  - default TIMEOUT and SYNC_STAGES constants, reused by the I/O bus interface block.
- Sub-module sync_bit: a parameterized N-stage synchronizer with async active-high reset to 0, instantiated for IOACK.
- FSM and counter live in iob_cycle_ctl.

Test Plan:
1. Read: nAS=0, IOCS=1, nWE=1 at edge 0; IOACK rises before edge 5 -> IOREQ=1 from edge 1, IOWE=0; nDTACK=0 at edge 7; IOREQ=0 at edge 7.
2. Release and next cycle: nAS=1 at edge 10, IOACK falls before edge 12 -> nDTACK=1 at edge 11; IDLE by edge 14; next strobe accepted.
3. Timeout: TIMEOUT=8, IOACK held 0 -> nBERR=0 exactly 9 edges after IOREQ rose; nDTACK stays 1; IOREQ=0.
4. Late ack after timeout: IOACK pulses high during ERR/RELEASE -> no nDTACK; FSM stays in RELEASE until IOACK=0.
5. Timeout race: IACS=1 and IOCS=1 with ack_s rising on the same edge the counter reaches TIMEOUT -> nDTACK=0, nBERR=1, IOIACK=1 throughout IOREQ.
6. Reset mid-REQ: RES asserted asynchronously mid-clock -> IOREQ=0 and nDTACK=1 before the next edge; after RES deasserts, Busy=0 and the first strobe is accepted normally.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared definitions for the IOB cycle controller and the I/O bus interface block.
package iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_TERM,
    ST_ERR,
    ST_RELEASE
  } iob_state_e;

  localparam int unsigned DEF_TIMEOUT     = 255;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Width of a counter that must hold every value 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer, clears to 0 on reset.
module sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/iob_cycle_ctl.sv
// Runs each IOB-selected CPU access as a four-phase request/acknowledge cycle
// on the slow I/O bus and terminates the CPU cycle with nDTACK or nBERR.
module iob_cycle_ctl
  import iob_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic RES,
  input  logic nAS,
  input  logic nWE,
  input  logic IOCS,
  input  logic IACS,
  input  logic IOACK,
  output logic IOREQ,
  output logic IOWE,
  output logic IOIACK,
  output logic nDTACK,
  output logic nBERR,
  output logic Busy
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  iob_state_e    state;
  logic [CW-1:0] cnt;
  logic          ack_s;

  sync_bit #(.N(SYNC_STAGES)) u_ack_sync (
    .clk (CLK),
    .rst (RES),
    .d   (IOACK),
    .q   (ack_s)
  );

  // Cycle FSM, timeout counter and registered bus/CPU outputs
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      IOREQ  <= 1'b0;
      IOWE   <= 1'b0;
      IOIACK <= 1'b0;
      nDTACK <= 1'b1;
      nBERR  <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!nAS && IOCS) begin
            IOWE   <= ~nWE;
            IOIACK <= IACS;
            IOREQ  <= 1'b1;
            Busy   <= 1'b1;
            cnt    <= '0;
            state  <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Counter saturates so the compare below can never be skipped
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (ack_s) begin
            IOREQ  <= 1'b0;
            nDTACK <= 1'b0;
            state  <= ST_TERM;
          end else if (cnt == CNT_MAX) begin
            IOREQ <= 1'b0;
            nBERR <= 1'b0;
            state <= ST_ERR;
          end else if (nAS) begin
            IOREQ <= 1'b0;
            state <= ST_RELEASE;
          end
        end

        ST_TERM: begin
          if (nAS) begin
            nDTACK <= 1'b1;
            state  <= ST_RELEASE;
          end
        end

        ST_ERR: begin
          if (nAS) begin
            nBERR <= 1'b1;
            state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // Hold off until the I/O side has dropped its acknowledge
          if (!ack_s && nAS) begin
            IOWE   <= 1'b0;
            IOIACK <= 1'b0;
            Busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          IOREQ  <= 1'b0;
          IOWE   <= 1'b0;
          IOIACK <= 1'b0;
          nDTACK <= 1'b1;
          nBERR  <= 1'b1;
          Busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cycle_ctl.sv
// Randomized bench for iob_cycle_ctl: each CPU cycle is described by event
// times (ack arrival, strobe release) and the expected waveform is derived
// from those times arithmetically.
module tb_iob_cycle_ctl;

  localparam int S = 2;
  localparam int T = 8;

  logic CLK = 1'b0;
  logic RES, nAS, nWE, IOCS, IACS, IOACK;
  logic IOREQ, IOWE, IOIACK, nDTACK, nBERR, Busy;

  int n_checks = 0;
  int n_errors = 0;

  iob_cycle_ctl #(.SYNC_STAGES(S), .TIMEOUT(T)) dut (
    .CLK    (CLK),
    .RES    (RES),
    .nAS    (nAS),
    .nWE    (nWE),
    .IOCS   (IOCS),
    .IACS   (IACS),
    .IOACK  (IOACK),
    .IOREQ  (IOREQ),
    .IOWE   (IOWE),
    .IOIACK (IOIACK),
    .nDTACK (nDTACK),
    .nBERR  (nBERR),
    .Busy   (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ioreq"},  IOREQ,  0);
    chk({tag, ".iowe"},   IOWE,   0);
    chk({tag, ".ioiack"}, IOIACK, 0);
    chk({tag, ".ndtack"}, nDTACK, 1);
    chk({tag, ".nberr"},  nBERR,  1);
    chk({tag, ".busy"},   Busy,   0);
  endtask

  // One CPU cycle. Edge 0 samples the strobe. ack_at: first edge IOACK is
  // sampled high (0 = never). nas_sel: first edge nAS is sampled high
  // (0 = after the natural termination plus gap edges).
  task automatic run_txn(input bit we, input bit iack, input int ack_at,
                         input int nas_sel, input int gap);
    bit has_ack;
    int ea, et, en, nas_up, e_end, rel, idle, ack_off, last, kind;
    has_ack = (ack_at > 0);
    ea = has_ack ? ack_at + S : 1 << 20;
    et = T + 1;
    en = (ea < et) ? ea : et;
    nas_up = (nas_sel > 0) ? nas_sel : en + gap;
    if (ea <= et && ea <= nas_up) begin kind = 0; e_end = ea; end
    else if (et <= nas_up)        begin kind = 1; e_end = et; end
    else                          begin kind = 2; e_end = nas_up; end
    rel = (kind == 2) ? e_end : ((nas_up > e_end + 1) ? nas_up : e_end + 1);
    ack_off = has_ack ? (((ack_at > e_end) ? ack_at : e_end) + 1 + int'($urandom_range(3))) : 0;
    idle = rel + 1;
    if (has_ack && idle >= ack_at + S && idle < ack_off + S) idle = ack_off + S;
    last = ((idle > ack_off + S) ? idle : ack_off + S) + 1;

    nAS = 1'b0; IOCS = 1'b1; nWE = ~we; IACS = iack; IOACK = 1'b0;
    for (int e = 0; e <= last; e++) begin
      @(posedge CLK); #1;
      chk($sformatf("ioreq@%0d", e),  IOREQ,  (e < e_end));
      chk($sformatf("ndtack@%0d", e), nDTACK, !(kind == 0 && e >= e_end && e < rel));
      chk($sformatf("nberr@%0d", e),  nBERR,  !(kind == 1 && e >= e_end && e < rel));
      chk($sformatf("busy@%0d", e),   Busy,   (e < idle));
      chk($sformatf("iowe@%0d", e),   IOWE,   (e < idle) && we);
      chk($sformatf("ioiack@%0d", e), IOIACK, (e < idle) && iack);
      nAS   = (e + 1 < nas_up) ? 1'b0 : 1'b1;
      IOCS  = nAS ? 1'($urandom) : 1'b1;
      nWE   = 1'($urandom);
      IACS  = 1'($urandom);
      IOACK = has_ack && (e + 1 >= ack_at) && (e + 1 < ack_off);
    end
    nAS = 1'b1; IOCS = 1'b0; IOACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b1; nAS = 1'b1; nWE = 1'b1; IOCS = 1'b0; IACS = 1'b0; IOACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_idle("rst");
    RES = 1'b0;
    @(posedge CLK); #1 check_idle("post_rst");

    // Strobes without IOCS are ignored
    for (int i = 0; i < 4; i++) begin
      nAS = 1'b0; IOCS = 1'b0; IACS = 1'($urandom); nWE = 1'($urandom);
      @(posedge CLK); #1;
      chk("ign.ioreq", IOREQ, 0);
      chk("ign.busy", Busy, 0);
    end
    nAS = 1'b1; IACS = 1'b0;
    @(posedge CLK); #1;

    // Directed cycles
    run_txn(0, 0, 5, 0, 3);           // read, acked
    run_txn(1, 0, 3, 0, 0);           // write, strobe released with ack
    run_txn(0, 0, 0, 0, 2);           // timeout, no ack
    run_txn(1, 0, 12, 0, 1);          // ack arrives after timeout
    run_txn(0, 1, T + 1 - S, 0, 2);   // ack coincides with timeout, iack cycle
    run_txn(1, 1, 6, 4, 0);           // aborted, late ack absorbed
    run_txn(0, 0, 0, 3, 0);           // aborted, no ack

    // Reset while in REQ
    nAS = 1'b0; IOCS = 1'b1; nWE = 1'b0; IACS = 1'b1;
    @(posedge CLK); #1 chk("rq.ioreq", IOREQ, 1);
    @(posedge CLK); #2 RES = 1'b1;
    #1 check_idle("rq_rst");
    nAS = 1'b1; IOCS = 1'b0;
    @(posedge CLK); #1 RES = 1'b0;
    @(posedge CLK); #1 check_idle("rq_after");

    // Reset while terminating with nDTACK
    nAS = 1'b0; IOCS = 1'b1; nWE = 1'b1; IACS = 1'b0;
    @(posedge CLK); #1 IOACK = 1'b1;
    repeat (S + 1) @(posedge CLK);
    #1 chk("tm.ndtack", nDTACK, 0);
    #2 RES = 1'b1;
    #1 check_idle("tm_rst");
    nAS = 1'b1; IOCS = 1'b0; IOACK = 1'b0;
    @(posedge CLK); #1 RES = 1'b0;
    @(posedge CLK); #1 check_idle("tm_after");
    run_txn(1, 0, 2, 0, 1);           // first cycle after reset

    // Random cycles
    for (int i = 0; i < 40; i++) begin
      int a, n;
      a = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(14, 1));
      n = ($urandom_range(4) == 0) ? int'($urandom_range(12, 1)) : 0;
      run_txn(1'($urandom), 1'($urandom), a, n, int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
